decode_stage_hz: RTL
====================

Name: decode_stage_hz

Overview:
Parametrised ID stage for the 5-stage MIPS pipeline. It holds the register file, decodes control for R-type, lw, sw and beq, sign-extends the immediate, and registers everything into the ID/EX pipeline register. Compared with the previous decode stage it adds load-use hazard detection with stall and bubble insertion, branch flush, a hardwired zero register, an ID/EX valid bit and a saturating stall counter.

Parameters:
DATA_W, 32, datapath and register width.
NUM_REGS, 32, register-file depth (power of 2).
RA_W, $clog2(NUM_REGS), register address width (derived, not overridden).
STALL_CNT_W, 16, stall counter width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
wb_reg_write  in  1  WB write enable
wb_write_reg_location  in  RA_W  WB destination
mem_wb_write_data  in  DATA_W  WB data
if_id_instr  in  32  fetched instruction
if_id_npc  in  DATA_W  PC+1 from IF
if_id_valid  in  1  IF/ID holds a real instruction
flush  in  1  branch taken; squash instruction in ID
pc_write  out  1  0 = hold PC (stall)
if_id_write  out  1  0 = hold IF/ID (stall)
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_wb  out  2  {RegWrite, MemtoReg}
id_ex_mem  out  3  {Branch, MemRead, MemWrite}
id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}
id_ex_npc  out  DATA_W  registered NPC
id_ex_readdat1  out  DATA_W  rs data
id_ex_readdat2  out  DATA_W  rt data
id_ex_sign_ext  out  DATA_W  sign-extended instr[15:0]
id_ex_instr_bits_20_16  out  RA_W  rt
id_ex_instr_bits_15_11  out  RA_W  rd
illegal_op  out  1  registered; 1 for one cycle when a valid unknown opcode was decoded
stall_count  out  STALL_CNT_W  cycles stalled, saturating

Behaviour:
- Reset (rst=0, async): all id_ex_* outputs, illegal_op and stall_count clear to 0. pc_write and if_id_write read 1. Register file clears to 0.
- Decode on opcode instr[31:26]:
  - 0x00 R-type: wb=10, mem=000, ex=1100
  - 0x23 lw: wb=11, mem=010, ex=0001
  - 0x2B sw: wb=00, mem=001, ex=0001
  - 0x04 beq: wb=00, mem=100, ex=0010
  - other: all control 0 and illegal_op=1 (only when the instruction is valid)
- Sign extension: id_ex_sign_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]}.
- Register file: written on posedge when wb_reg_write=1 and the address is nonzero. Writes to r0 are ignored. Reads are combinational and r0 always returns 0.
- Hazard detection (combinational): stall = id_ex_valid & id_ex_mem[1] & (id_ex_instr_bits_20_16 != 0) & (id_ex_instr_bits_20_16 == instr[25:21] | (id_ex_instr_bits_20_16 == instr[20:16] & opcode uses rt as a source, i.e. R-type, sw or beq)) & if_id_valid.
- On stall: pc_write=0 and if_id_write=0. ID/EX loads a bubble: valid=0 and wb/mem/ex=0; data fields are don't-care but still load. Stall lasts exactly 1 cycle per load-use pair.
- Flush: on the next edge ID/EX loads a bubble. Flush has priority over stall. When both are asserted, pc_write and if_id_write stay 1, so IF can redirect.
- Latency: 1 cycle from IF/ID to ID/EX. No enable; ID/EX updates every cycle.
- if_id_valid=0 is treated as a bubble: no stall, no illegal_op.
- stall_count increments on each stall cycle (not on flush) and saturates at all-ones.
- Reset asserted mid-stall clears everything immediately; the first post-reset cycle is not a stall.

Optional Feature:
DECODE_BYPASS_EN
- Defined: write-through. When wb_reg_write=1, the address is nonzero and it matches rs or rt, the read returns mem_wb_write_data in the same cycle.
- Undefined: the read returns the pre-write value. The dependent instruction sees new data one cycle later.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - the control-bit index constants for the wb, mem and ex fields
  - the ALUOp encodings
- Sub-module decode_regfile(DATA_W, NUM_REGS) contains the register file, the r0 handling and the bypass under the macro.

Test Plan:
- Reset: rst=0 with instr 0x00a41020 present → all id_ex_* = 0, stall_count=0. Release reset → next edge wb=10, ex=1100, rt=4, rd=2, valid=1.
- Decode sweep: 0x10000008 → mem=100, ex=0010, sign_ext=0x00000008. 0x8c820002 → wb=11, mem=010, ex=0001. 0xac820002 → mem=001. 0xfc000000 → illegal_op=1 and all control 0.
- Load-use: 0x8c820002 then 0x00421020 → one bubble cycle with valid=0, pc_write=0, if_id_write=0. Add issues next cycle; stall_count=1.
- Flush + stall together: the same pair with flush=1 on the stall cycle → bubble, pc_write=1, stall_count unchanged.
- Writeback: write 0x64 to r2, then read r2. With DECODE_BYPASS_EN the same-cycle read gives 0x64; without it gives 0 first, then 0x64. A write of 0x64 to r0 still reads 0.
- Saturation (STALL_CNT_W=2): 5 load-use stalls → stall_count=3.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-bit positions, ALUOp encodings
// and the opcode-to-control decoder used by the ID stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // wb = {RegWrite, MemtoReg}
  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  // mem = {Branch, MemRead, MemWrite}
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  // ex = {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_HI  = 2;
  localparam int EX_ALUOP_LO  = 1;
  localparam int EX_ALUSRC    = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]                 = 1'b1;
        c.ex[EX_REGDST]                   = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]     = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE]                 = 1'b1;
        c.wb[WB_MEMTOREG]                 = 1'b1;
        c.mem[MEM_MEMREAD]                = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]     = ALUOP_ADD;
        c.ex[EX_ALUSRC]                   = 1'b1;
      end
      OP_SW: begin
        c.mem[MEM_MEMWRITE]               = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]     = ALUOP_ADD;
        c.ex[EX_ALUSRC]                   = 1'b1;
      end
      OP_BEQ: begin
        c.mem[MEM_BRANCH]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]     = ALUOP_SUB;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with hardwired-zero r0, two combinational read ports.
// DECODE_BYPASS_EN makes a same-cycle writeback visible on the read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [RA_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [RA_W-1:0]   i_rs_addr,
  input  logic [RA_W-1:0]   i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rs_arr;
  logic [DATA_W-1:0] w_rt_arr;

  assign w_wr_ok = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_rs_arr = (i_rs_addr == '0) ? '0 : r_regs[i_rs_addr];
  assign w_rt_arr = (i_rt_addr == '0) ? '0 : r_regs[i_rt_addr];

`ifdef DECODE_BYPASS_EN
  // w_wr_ok already excludes r0, so the bypass can never leak data into r0 reads.
  assign o_rs_data = (w_wr_ok && i_wr_addr == i_rs_addr) ? i_wr_data : w_rs_arr;
  assign o_rt_data = (w_wr_ok && i_wr_addr == i_rt_addr) ? i_wr_data : w_rt_arr;
`else
  assign o_rs_data = w_rs_arr;
  assign o_rt_data = w_rt_arr;
`endif

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS ID stage with load-use stall, branch flush, ID/EX valid bit and a
// saturating stall counter. Optional write-through regfile: DECODE_BYPASS_EN.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int NUM_REGS    = 32,
  parameter  int STALL_CNT_W = 16,
  localparam int RA_W        = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_reg_write,
  input  logic [RA_W-1:0]        wb_write_reg_location,
  input  logic [DATA_W-1:0]      mem_wb_write_data,
  input  logic [31:0]            if_id_instr,
  input  logic [DATA_W-1:0]      if_id_npc,
  input  logic                   if_id_valid,
  input  logic                   flush,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_valid,
  output logic [1:0]             id_ex_wb,
  output logic [2:0]             id_ex_mem,
  output logic [3:0]             id_ex_execute,
  output logic [DATA_W-1:0]      id_ex_npc,
  output logic [DATA_W-1:0]      id_ex_readdat1,
  output logic [DATA_W-1:0]      id_ex_readdat2,
  output logic [DATA_W-1:0]      id_ex_sign_ext,
  output logic [RA_W-1:0]        id_ex_instr_bits_20_16,
  output logic [RA_W-1:0]        id_ex_instr_bits_15_11,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [5:0]        w_opcode;
  logic [RA_W-1:0]   w_rs;
  logic [RA_W-1:0]   w_rt;
  logic [RA_W-1:0]   w_rd;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_sign_ext;
  ctrl_t             w_ctrl;
  logic              w_uses_rt;
  logic              w_stall;
  logic              w_hold;
  logic              w_issue;

  assign w_opcode   = if_id_instr[31:26];
  assign w_rs       = if_id_instr[21 +: RA_W];
  assign w_rt       = if_id_instr[16 +: RA_W];
  assign w_rd       = if_id_instr[11 +: RA_W];
  assign w_sign_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
  assign w_ctrl     = decode_ctrl(w_opcode);

  decode_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wb_reg_write),
    .i_wr_addr (wb_write_reg_location),
    .i_wr_data (mem_wb_write_data),
    .i_rs_addr (w_rs),
    .i_rt_addr (w_rt),
    .o_rs_data (w_rs_data),
    .o_rt_data (w_rt_data)
  );

  assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);

  assign w_stall = id_ex_valid && id_ex_mem[MEM_MEMREAD] &&
                   (id_ex_instr_bits_20_16 != '0) &&
                   ((id_ex_instr_bits_20_16 == w_rs) ||
                    ((id_ex_instr_bits_20_16 == w_rt) && w_uses_rt)) &&
                   if_id_valid;

  // pc_write/if_id_write low means "hold": IF must keep PC and IF/ID stable this
  // cycle. A flush overrides the hold so IF is free to redirect to the target.
  assign w_hold      = w_stall && !flush;
  assign pc_write    = !w_hold;
  assign if_id_write = !w_hold;
  assign w_issue     = if_id_valid && !flush && !w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_valid            <= 1'b0;
      id_ex_wb               <= '0;
      id_ex_mem              <= '0;
      id_ex_execute          <= '0;
      id_ex_npc              <= '0;
      id_ex_readdat1         <= '0;
      id_ex_readdat2         <= '0;
      id_ex_sign_ext         <= '0;
      id_ex_instr_bits_20_16 <= '0;
      id_ex_instr_bits_15_11 <= '0;
      illegal_op             <= 1'b0;
    end else begin
      id_ex_valid            <= w_issue;
      id_ex_wb               <= w_issue ? w_ctrl.wb  : '0;
      id_ex_mem              <= w_issue ? w_ctrl.mem : '0;
      id_ex_execute          <= w_issue ? w_ctrl.ex  : '0;
      id_ex_npc              <= if_id_npc;
      id_ex_readdat1         <= w_rs_data;
      id_ex_readdat2         <= w_rt_data;
      id_ex_sign_ext         <= w_sign_ext;
      id_ex_instr_bits_20_16 <= w_rt;
      id_ex_instr_bits_15_11 <= w_rd;
      // Reported once per instruction: a stalled copy is re-decoded next cycle.
      illegal_op             <= w_issue && w_ctrl.illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (w_hold && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
